// File: rtl/perf_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_ctrl_if
// Description : MMIO request/response bundle for the performance-counter
//               controller. The block is always ready, so there is no
//               backpressure signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface perf_counter_ctrl_if #(
    parameter int DWIDTH = 32
) ();
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              resp_valid;
    logic [DWIDTH-1:0] resp_rdata;

    // Bus master (core side) issues requests and consumes read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  resp_valid, resp_rdata
    );

    // Peripheral side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output resp_valid, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/perf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_ctrl
// Description : 64-bit cycle and retired-instruction counters with enable,
//               clear and one-shot stop-at-limit sequencing. 32-bit MMIO
//               reads of a counter are made atomic by latching the high word
//               into a shared shadow register when the low word is read.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_ctrl #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          inst_retire,
    perf_counter_ctrl_if.slave bus,
    output logic               done
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_CYC_LO   = 3'd1;
    localparam logic [2:0] ADDR_CYC_HI   = 3'd2;
    localparam logic [2:0] ADDR_INST_LO  = 3'd3;
    localparam logic [2:0] ADDR_INST_HI  = 3'd4;
    localparam logic [2:0] ADDR_LIMIT_LO = 3'd5;
    localparam logic [2:0] ADDR_LIMIT_HI = 3'd6;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              state_q;
    logic [CWIDTH-1:0]   cyc_cnt_q;
    logic [CWIDTH-1:0]   inst_cnt_q;
    logic [CWIDTH-1:0]   limit_q;
    logic [DWIDTH-1:0]   hi_shadow_q;
    logic                en_q;
    logic                oneshot_q;
    logic                done_q;
    logic                resp_valid_q;
    logic [DWIDTH-1:0]   resp_rdata_q;

    logic [CWIDTH-1:0]   cyc_inc_d;
    logic [CWIDTH-1:0]   inst_inc_d;
    logic                limit_hit_d;
    logic                wr_en_d;
    logic                rd_en_d;
    logic [DWIDTH-1:0]   rd_data_d;
    logic [DWIDTH-1:0]   shadow_d;

    assign cyc_inc_d   = cyc_cnt_q + CWIDTH'(1);
    assign inst_inc_d  = inst_cnt_q + CWIDTH'(1);
    // Limit compare is against the post-increment value so the final retire
    // is committed and the counter reads exactly the limit afterwards.
    assign limit_hit_d = (state_q == ST_RUNNING) && oneshot_q && inst_retire &&
                         (inst_inc_d == limit_q);
    assign wr_en_d     = bus.req_valid && bus.req_we;
    assign rd_en_d     = bus.req_valid && !bus.req_we;

    // Read mux over request-cycle register values; HI words come from the shadow.
    always_comb begin
        rd_data_d = '0;
        shadow_d  = cyc_cnt_q[CWIDTH-1:DWIDTH];
        case (bus.req_addr)
            ADDR_CTRL:     rd_data_d[3:0] = {done_q, oneshot_q, 1'b0, en_q};
            ADDR_CYC_LO:   rd_data_d = cyc_cnt_q[DWIDTH-1:0];
            ADDR_CYC_HI:   rd_data_d = hi_shadow_q;
            ADDR_INST_LO: begin
                rd_data_d = inst_cnt_q[DWIDTH-1:0];
                shadow_d  = inst_cnt_q[CWIDTH-1:DWIDTH];
            end
            ADDR_INST_HI:  rd_data_d = hi_shadow_q;
            ADDR_LIMIT_LO: rd_data_d = limit_q[DWIDTH-1:0];
            ADDR_LIMIT_HI: rd_data_d = limit_q[CWIDTH-1:DWIDTH];
            default:       rd_data_d = '0;
        endcase
    end

    // Counter FSM, register writes and registered read response.
    // Software CTRL writes are applied after counting so they override both
    // the increment (CLR wins) and a same-cycle limit hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STOPPED;
            cyc_cnt_q    <= '0;
            inst_cnt_q   <= '0;
            limit_q      <= '0;
            hi_shadow_q  <= '0;
            en_q         <= 1'b0;
            oneshot_q    <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;

            if (state_q == ST_RUNNING) begin
                cyc_cnt_q <= cyc_inc_d;
                if (inst_retire) begin
                    inst_cnt_q <= inst_inc_d;
                end
                if (limit_hit_d) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
            end

            if (wr_en_d) begin
                case (bus.req_addr)
                    ADDR_CTRL: begin
                        en_q      <= bus.req_wdata[0];
                        oneshot_q <= bus.req_wdata[2];
                        state_q   <= bus.req_wdata[0] ? ST_RUNNING : ST_STOPPED;
                        done_q    <= 1'b0;
                        if (bus.req_wdata[1]) begin
                            cyc_cnt_q  <= '0;
                            inst_cnt_q <= '0;
                        end
                    end
                    ADDR_LIMIT_LO: limit_q[DWIDTH-1:0]      <= bus.req_wdata;
                    ADDR_LIMIT_HI: limit_q[CWIDTH-1:DWIDTH] <= bus.req_wdata;
                    default: ;
                endcase
            end

            if (rd_en_d) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= rd_data_d;
                if ((bus.req_addr == ADDR_CYC_LO) || (bus.req_addr == ADDR_INST_LO)) begin
                    hi_shadow_q <= shadow_d;
                end
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_counter_ctrl
// Description : Scoreboard bench for perf_counter_ctrl. A full-width instance
//               covers the main register behaviour; a narrow instance
//               (DWIDTH=4, CWIDTH=8) makes shadow carry and counter wrap
//               reachable in a few hundred cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    logic inst_retire;
    logic inst_retire_s;
    logic done;
    logic done_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q_big[$];
    exp_t q_small[$];

    perf_counter_ctrl_if #(.DWIDTH(32)) b  ();
    perf_counter_ctrl_if #(.DWIDTH(4))  sb ();

    perf_counter_ctrl #(.DWIDTH(32), .CWIDTH(64)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .inst_retire (inst_retire),
        .bus         (b),
        .done        (done)
    );

    perf_counter_ctrl #(.DWIDTH(4), .CWIDTH(8)) u_small (
        .clk         (clk),
        .rst         (rst_s),
        .inst_retire (inst_retire_s),
        .bus         (sb),
        .done        (done_s)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input bit s, input logic [2:0] a, input logic [31:0] d);
        if (s) begin
            sb.req_valid = 1'b1; sb.req_we = 1'b1; sb.req_addr = a; sb.req_wdata = d[3:0];
        end else begin
            b.req_valid = 1'b1; b.req_we = 1'b1; b.req_addr = a; b.req_wdata = d;
        end
        @(negedge clk);
        b.req_valid = 1'b0;  b.req_we = 1'b0;
        sb.req_valid = 1'b0; sb.req_we = 1'b0;
    endtask

    task automatic rd(input bit s, input logic [2:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.exp  = e;
        x.name = nm;
        if (s) begin
            q_small.push_back(x);
            sb.req_valid = 1'b1; sb.req_we = 1'b0; sb.req_addr = a;
        end else begin
            q_big.push_back(x);
            b.req_valid = 1'b1; b.req_we = 1'b0; b.req_addr = a;
        end
        @(negedge clk);
        b.req_valid  = 1'b0;
        sb.req_valid = 1'b0;
    endtask

    task automatic retire(input bit s, input int n);
        if (s) inst_retire_s = 1'b1; else inst_retire = 1'b1;
        repeat (n) @(negedge clk);
        inst_retire   = 1'b0;
        inst_retire_s = 1'b0;
    endtask

    // Monitor: every presented response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b.resp_valid === 1'b1) begin
                if (q_big.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL big_unexpected_resp: got resp_valid=1 data 0x%0h expected no response", b.resp_rdata);
                end else begin
                    e = q_big.pop_front();
                    chk(e.name, b.resp_rdata, e.exp);
                end
            end
            if (sb.resp_valid === 1'b1) begin
                if (q_small.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL small_unexpected_resp: got resp_valid=1 data 0x%0h expected no response", sb.resp_rdata);
                end else begin
                    e = q_small.pop_front();
                    chk(e.name, {28'd0, sb.resp_rdata}, e.exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        inst_retire = 1'b0; inst_retire_s = 1'b0;
        b.req_valid  = 1'b0; b.req_we  = 1'b0; b.req_addr  = 3'd0; b.req_wdata  = '0;
        sb.req_valid = 1'b0; sb.req_we = 1'b0; sb.req_addr = 3'd0; sb.req_wdata = '0;
        idle(3);
        rst = 1'b0; rst_s = 1'b0;

        // Reset state
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_resp_valid", {31'd0, b.resp_valid}, 32'd0);
        for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'd0, "rst_read");

        // Enable, count 10 idle cycles
        wr(0, 3'd0, 32'd1);
        idle(10);
        rd(0, 3'd1, 32'd10, "t1_cyc_lo");
        rd(0, 3'd2, 32'd0,  "t1_cyc_hi");

        // Clear+run, 5 retires, stop, frozen counters
        wr(0, 3'd0, 32'd3);
        retire(0, 5);
        wr(0, 3'd0, 32'd0);
        idle(20);
        rd(0, 3'd3, 32'd5, "t2_inst_lo_a");
        rd(0, 3'd3, 32'd5, "t2_inst_lo_b");
        rd(0, 3'd1, 32'd6, "t2_cyc_lo_a");
        rd(0, 3'd1, 32'd6, "t2_cyc_lo_b");
        rd(0, 3'd2, 32'd0, "t2_cyc_hi");

        // One-shot limit of 3
        wr(0, 3'd5, 32'd3);
        wr(0, 3'd6, 32'd0);
        wr(0, 3'd0, 32'd2);
        wr(0, 3'd0, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            inst_retire = 1'b1;
            @(negedge clk);
            chk("t4_done_level", {31'd0, done}, (i >= 3) ? 32'd1 : 32'd0);
        end
        inst_retire = 1'b0;
        rd(0, 3'd3, 32'd3,  "t4_inst_lo");
        rd(0, 3'd0, 32'hD,  "t4_ctrl_done");
        rd(0, 3'd5, 32'd3,  "t4_limit_lo");
        rd(0, 3'd6, 32'd0,  "t4_limit_hi");
        wr(0, 3'd0, 32'd1);
        chk("t4_done_cleared", {31'd0, done}, 32'd0);
        retire(0, 2);
        rd(0, 3'd3, 32'd5,  "t4_inst_resume");
        rd(0, 3'd0, 32'd1,  "t4_ctrl_run");

        // CLR beats a simultaneous retire
        wr(0, 3'd0, 32'd3);
        retire(0, 7);
        inst_retire = 1'b1;
        wr(0, 3'd0, 32'd3);
        inst_retire = 1'b0;
        rd(0, 3'd1, 32'd0, "t5_cyc_cleared");
        rd(0, 3'd3, 32'd0, "t5_inst_cleared");
        retire(0, 2);
        rd(0, 3'd3, 32'd2, "t5_inst_resume");
        rd(0, 3'd1, 32'd5, "t5_cyc_resume");

        // Counter addresses and address 7 are not writable
        wr(0, 3'd0, 32'd2);
        wr(0, 3'd1, 32'h1234);
        wr(0, 3'd3, 32'h5678);
        wr(0, 3'd7, 32'hAA);
        rd(0, 3'd1, 32'd0, "t6_cyc_not_writable");
        rd(0, 3'd3, 32'd0, "t6_inst_not_writable");
        rd(0, 3'd7, 32'd0, "t6_addr7");

        // Reach DONE, then reset together with a read request
        wr(0, 3'd0, 32'd7);
        retire(0, 3);
        chk("t7_done_before_rst", {31'd0, done}, 32'd1);
        b.req_valid = 1'b1; b.req_we = 1'b0; b.req_addr = 3'd1;
        rst = 1'b1;
        @(negedge clk);
        b.req_valid = 1'b0;
        rst = 1'b0;
        chk("t7_no_resp_after_rst", {31'd0, b.resp_valid}, 32'd0);
        chk("t7_done_after_rst", {31'd0, done}, 32'd0);
        for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'd0, "t7_read_after_rst");

        // Narrow instance: HI read returns the shadow, not the live word
        wr(1, 3'd0, 32'd3);
        idle(13);
        rd(1, 3'd1, 32'hD, "s_cyc_lo_pre_carry");
        idle(5);
        rd(1, 3'd2, 32'h0, "s_cyc_hi_shadow");
        rd(1, 3'd1, 32'h4, "s_cyc_lo_post_carry");
        rd(1, 3'd2, 32'h1, "s_cyc_hi_reloaded");

        // Narrow instance: limit 0 one-shot is hit only after a full wrap
        wr(1, 3'd0, 32'd7);
        retire(1, 255);
        chk("s_not_done_at_255", {31'd0, done_s}, 32'd0);
        rd(1, 3'd3, 32'hF, "s_inst_lo_255");
        rd(1, 3'd4, 32'hF, "s_inst_hi_255");
        retire(1, 1);
        chk("s_done_after_wrap", {31'd0, done_s}, 32'd1);
        idle(3);
        rd(1, 3'd3, 32'h0, "s_inst_lo_wrapped");
        rd(1, 3'd4, 32'h0, "s_inst_hi_wrapped");
        rd(1, 3'd0, 32'hD, "s_ctrl_done");
        rd(1, 3'd1, 32'h2, "s_cyc_lo_wrapped");
        rd(1, 3'd2, 32'h0, "s_cyc_hi_wrapped");

        idle(3);
        chk("scoreboard_drained", q_big.size() + q_small.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
